ysyx_bus_arb: RTL and testbench



---
 rtl/ysyx_bus_pkg.sv | 31 +++
 rtl/ysyx_bus_arb.sv | 218 +++++++++++++++++++++
 tb/tb_ysyx_bus_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_bus_pkg.sv
// Shared definitions for the L1 bus arbiter: FSM state encoding,
// AXI burst-length width and the full-strobe constant.
// YSYX_XLEN supplies the address/data width; it defaults to 64 when the
// surrounding build does not provide it.

`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif

package ysyx_bus_pkg;

   localparam int         AXLEN_W   = 8;
   localparam logic [7:0] STRB_FULL = 8'hff;

   typedef enum logic [2:0] {
      IDLE,
      I_AR,
      I_R,
      D_AR,
      D_R,
      D_W,
      D_B
   } bus_arb_state_e;

   // Identifies which read requester was granted most recently.
   typedef enum logic {
      SRC_I,
      SRC_D
   } bus_src_e;

endpackage

// File: rtl/ysyx_bus_arb.sv
// ysyx_bus_arb: shares one simplified AXI4 master port between the L1
// instruction cache (reads only) and the L1 data cache (reads and writes).
// Only one transaction is outstanding at a time. Writes always win in IDLE.
// Build option YSYX_BUS_ARB_RR_EN: when defined, contested reads alternate
// round-robin between I and D; when undefined, a D read beats an I read.

module ysyx_bus_arb
   import ysyx_bus_pkg::*;
#(
   parameter int XLEN      = `YSYX_XLEN,
   parameter int L1I_BEATS = 4,
   parameter int L1D_BEATS = 1
) (
   input  logic               clock,
   input  logic               reset,
   // instruction-cache refill port
   input  logic               l1i_arvalid,
   input  logic [XLEN-1:0]    l1i_araddr,
   output logic               l1i_rready,
   output logic               l1i_rvalid,
   output logic [XLEN-1:0]    l1i_rdata,
   output logic               l1i_rlast,
   // data-cache load/store port
   input  logic               l1d_arvalid,
   input  logic [XLEN-1:0]    l1d_araddr,
   input  logic [7:0]         l1d_rstrb,
   output logic               l1d_rready,
   output logic               l1d_rvalid,
   output logic [XLEN-1:0]    l1d_rdata,
   output logic               l1d_rlast,
   input  logic               l1d_awvalid,
   input  logic [XLEN-1:0]    l1d_awaddr,
   input  logic               l1d_wvalid,
   input  logic [XLEN-1:0]    l1d_wdata,
   input  logic [7:0]         l1d_wstrb,
   output logic               l1d_wready,
   // downstream AXI master
   output logic               mem_arvalid,
   input  logic               mem_arready,
   output logic [XLEN-1:0]    mem_araddr,
   output logic [AXLEN_W-1:0] mem_arlen,
   output logic [7:0]         mem_arstrb,
   input  logic               mem_rvalid,
   output logic               mem_rready,
   input  logic [XLEN-1:0]    mem_rdata,
   input  logic               mem_rlast,
   output logic               mem_awvalid,
   input  logic               mem_awready,
   output logic [XLEN-1:0]    mem_awaddr,
   output logic               mem_wvalid,
   input  logic               mem_wready,
   output logic [XLEN-1:0]    mem_wdata,
   output logic [7:0]         mem_wstrb,
   input  logic               mem_bvalid,
   output logic               mem_bready
);

   bus_arb_state_e state;
`ifdef YSYX_BUS_ARB_RR_EN
   bus_src_e       rr_last;
`endif

   logic wr_req;
   logic grant_i;
   logic grant_d;
   logic aw_done;
   logic w_done;

   // Arbitration and write-handshake bookkeeping for the current cycle.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      // The write is masked during its own completion pulse so a requester
      // that drops valid one cycle late is not issued twice.
      wr_req  = l1d_awvalid & l1d_wvalid & ~l1d_wready;
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (!wr_req) begin
`ifdef YSYX_BUS_ARB_RR_EN
         grant_i = l1i_arvalid & (~l1d_arvalid | (rr_last == SRC_D));
`else
         grant_i = l1i_arvalid & ~l1d_arvalid;
`endif
         grant_d = l1d_arvalid & ~grant_i;
      end
      aw_done = ~mem_awvalid | mem_awready;
      w_done  = ~mem_wvalid  | mem_wready;
   end

   // Forward each read beat straight to the granted port only.
   always_comb begin
      l1i_rdata  = mem_rdata;
      l1d_rdata  = mem_rdata;
      l1i_rvalid = 1'b0;
      l1i_rlast  = 1'b0;
      l1d_rvalid = 1'b0;
      l1d_rlast  = 1'b0;
      if (state == I_R) begin
         l1i_rvalid = mem_rvalid;
         l1i_rlast  = mem_rvalid & mem_rlast;
      end
      if (state == D_R) begin
         l1d_rvalid = mem_rvalid;
         l1d_rlast  = mem_rvalid & mem_rlast;
      end
   end

   // Transaction FSM with registered handshake outputs and latched request.
   // NOTE: state and registered outputs use non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
`ifdef YSYX_BUS_ARB_RR_EN
         rr_last     <= SRC_D;
`endif
         mem_arvalid <= 1'b0;
         mem_araddr  <= '0;
         mem_arlen   <= '0;
         mem_arstrb  <= '0;
         mem_rready  <= 1'b0;
         mem_awvalid <= 1'b0;
         mem_awaddr  <= '0;
         mem_wvalid  <= 1'b0;
         mem_wdata   <= '0;
         mem_wstrb   <= '0;
         mem_bready  <= 1'b0;
         l1i_rready  <= 1'b0;
         l1d_rready  <= 1'b0;
         l1d_wready  <= 1'b0;
      end else begin
         l1i_rready <= 1'b0;
         l1d_rready <= 1'b0;
         l1d_wready <= 1'b0;
         case (state)
            IDLE: begin
               if (wr_req) begin
                  state       <= D_W;
                  mem_awvalid <= 1'b1;
                  mem_wvalid  <= 1'b1;
                  mem_awaddr  <= l1d_awaddr;
                  mem_wdata   <= l1d_wdata;
                  mem_wstrb   <= l1d_wstrb;
               end else if (grant_i) begin
                  state       <= I_AR;
                  mem_arvalid <= 1'b1;
                  mem_araddr  <= l1i_araddr;
                  mem_arlen   <= AXLEN_W'(L1I_BEATS - 1);
                  mem_arstrb  <= STRB_FULL;
`ifdef YSYX_BUS_ARB_RR_EN
                  rr_last     <= SRC_I;
`endif
               end else if (grant_d) begin
                  state       <= D_AR;
                  mem_arvalid <= 1'b1;
                  mem_araddr  <= l1d_araddr;
                  mem_arlen   <= AXLEN_W'(L1D_BEATS - 1);
                  mem_arstrb  <= l1d_rstrb;
`ifdef YSYX_BUS_ARB_RR_EN
                  rr_last     <= SRC_D;
`endif
               end
            end
            I_AR: begin
               if (mem_arready) begin
                  state       <= I_R;
                  mem_arvalid <= 1'b0;
                  mem_rready  <= 1'b1;
                  l1i_rready  <= 1'b1;
               end
            end
            D_AR: begin
               if (mem_arready) begin
                  state       <= D_R;
                  mem_arvalid <= 1'b0;
                  mem_rready  <= 1'b1;
                  l1d_rready  <= 1'b1;
               end
            end
            I_R, D_R: begin
               if (mem_rvalid && mem_rlast) begin
                  state      <= IDLE;
                  mem_rready <= 1'b0;
               end
            end
            D_W: begin
               if (mem_awready) mem_awvalid <= 1'b0;
               if (mem_wready)  mem_wvalid  <= 1'b0;
               if (aw_done && w_done) begin
                  state      <= D_B;
                  mem_bready <= 1'b1;
               end
            end
            D_B: begin
               if (mem_bvalid) begin
                  state      <= IDLE;
                  mem_bready <= 1'b0;
                  l1d_wready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   logic [AXLEN_W-1:0] beat_cnt;

   // Cross-check that rlast arrives on the beat implied by arlen.
   always_ff @(posedge clock) begin
      if (reset || state == I_AR || state == D_AR) begin
         beat_cnt <= '0;
      end else if (mem_rvalid && mem_rready) begin
         beat_cnt <= beat_cnt + AXLEN_W'(1);
         if (mem_rlast) assert (beat_cnt == mem_arlen);
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_bus_arb.sv
// Directed testbench for ysyx_bus_arb: ifetch burst, contested reads,
// write priority, AW/W skew, reset mid-burst and data-read strobe.

module tb_ysyx_bus_arb;

   localparam int XLEN = 64;

   logic            clock;
   logic            reset;
   logic            l1i_arvalid;
   logic [XLEN-1:0] l1i_araddr;
   logic            l1i_rready;
   logic            l1i_rvalid;
   logic [XLEN-1:0] l1i_rdata;
   logic            l1i_rlast;
   logic            l1d_arvalid;
   logic [XLEN-1:0] l1d_araddr;
   logic [7:0]      l1d_rstrb;
   logic            l1d_rready;
   logic            l1d_rvalid;
   logic [XLEN-1:0] l1d_rdata;
   logic            l1d_rlast;
   logic            l1d_awvalid;
   logic [XLEN-1:0] l1d_awaddr;
   logic            l1d_wvalid;
   logic [XLEN-1:0] l1d_wdata;
   logic [7:0]      l1d_wstrb;
   logic            l1d_wready;
   logic            mem_arvalid;
   logic            mem_arready;
   logic [XLEN-1:0] mem_araddr;
   logic [7:0]      mem_arlen;
   logic [7:0]      mem_arstrb;
   logic            mem_rvalid;
   logic            mem_rready;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_rlast;
   logic            mem_awvalid;
   logic            mem_awready;
   logic [XLEN-1:0] mem_awaddr;
   logic            mem_wvalid;
   logic            mem_wready;
   logic [XLEN-1:0] mem_wdata;
   logic [7:0]      mem_wstrb;
   logic            mem_bvalid;
   logic            mem_bready;

   int n_assert = 0;
   int n_fail   = 0;

   ysyx_bus_arb #(.XLEN(XLEN), .L1I_BEATS(4), .L1D_BEATS(1)) dut (
      .clock       (clock),
      .reset       (reset),
      .l1i_arvalid (l1i_arvalid),
      .l1i_araddr  (l1i_araddr),
      .l1i_rready  (l1i_rready),
      .l1i_rvalid  (l1i_rvalid),
      .l1i_rdata   (l1i_rdata),
      .l1i_rlast   (l1i_rlast),
      .l1d_arvalid (l1d_arvalid),
      .l1d_araddr  (l1d_araddr),
      .l1d_rstrb   (l1d_rstrb),
      .l1d_rready  (l1d_rready),
      .l1d_rvalid  (l1d_rvalid),
      .l1d_rdata   (l1d_rdata),
      .l1d_rlast   (l1d_rlast),
      .l1d_awvalid (l1d_awvalid),
      .l1d_awaddr  (l1d_awaddr),
      .l1d_wvalid  (l1d_wvalid),
      .l1d_wdata   (l1d_wdata),
      .l1d_wstrb   (l1d_wstrb),
      .l1d_wready  (l1d_wready),
      .mem_arvalid (mem_arvalid),
      .mem_arready (mem_arready),
      .mem_araddr  (mem_araddr),
      .mem_arlen   (mem_arlen),
      .mem_arstrb  (mem_arstrb),
      .mem_rvalid  (mem_rvalid),
      .mem_rready  (mem_rready),
      .mem_rdata   (mem_rdata),
      .mem_rlast   (mem_rlast),
      .mem_awvalid (mem_awvalid),
      .mem_awready (mem_awready),
      .mem_awaddr  (mem_awaddr),
      .mem_wvalid  (mem_wvalid),
      .mem_wready  (mem_wready),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_bvalid  (mem_bvalid),
      .mem_bready  (mem_bready)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Safety net: the directed sequence is bounded, but never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, required end before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Every handshake output of the arbiter is low.
   task automatic check_quiet(input string tag);
      check({tag, "_arvalid"}, 64'(mem_arvalid), 64'd0);
      check({tag, "_rready"},  64'(mem_rready),  64'd0);
      check({tag, "_awvalid"}, 64'(mem_awvalid), 64'd0);
      check({tag, "_wvalid"},  64'(mem_wvalid),  64'd0);
      check({tag, "_bready"},  64'(mem_bready),  64'd0);
      check({tag, "_i_rready"}, 64'(l1i_rready), 64'd0);
      check({tag, "_i_rvalid"}, 64'(l1i_rvalid), 64'd0);
      check({tag, "_i_rlast"},  64'(l1i_rlast),  64'd0);
      check({tag, "_d_rready"}, 64'(l1d_rready), 64'd0);
      check({tag, "_d_rvalid"}, 64'(l1d_rvalid), 64'd0);
      check({tag, "_d_rlast"},  64'(l1d_rlast),  64'd0);
      check({tag, "_d_wready"}, 64'(l1d_wready), 64'd0);
   endtask

   // Called in the AR state: checks the request, accepts it, returns beats
   // 0x11, 0x22, ... and ends in the IDLE cycle after the last beat.
   task automatic do_read(input string tag, input logic [63:0] exp_addr,
                          input logic [7:0] exp_len, input logic [7:0] exp_strb,
                          input bit is_i, input bit hold);
      check({tag, "_arvalid"}, 64'(mem_arvalid), 64'd1);
      check({tag, "_araddr"},  mem_araddr, exp_addr);
      check({tag, "_arlen"},   64'(mem_arlen), 64'(exp_len));
      check({tag, "_arstrb"},  64'(mem_arstrb), 64'(exp_strb));
      mem_arready = 1'b1;
      tick();
      mem_arready = 1'b0;
      check({tag, "_i_rready"}, 64'(l1i_rready), 64'(is_i));
      check({tag, "_d_rready"}, 64'(l1d_rready), 64'(!is_i));
      check({tag, "_arvalid_off"}, 64'(mem_arvalid), 64'd0);
      check({tag, "_mem_rready"}, 64'(mem_rready), 64'd1);
      if (!hold) begin
         if (is_i) l1i_arvalid = 1'b0;
         else      l1d_arvalid = 1'b0;
      end
      for (int b = 0; b <= int'(exp_len); b++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 64'(64'h11 * (b + 1));
         mem_rlast  = (b == int'(exp_len));
         #1;
         check({tag, "_rvalid"}, 64'(is_i ? l1i_rvalid : l1d_rvalid), 64'd1);
         check({tag, "_rdata"},  is_i ? l1i_rdata : l1d_rdata, 64'(64'h11 * (b + 1)));
         check({tag, "_rlast"},  64'(is_i ? l1i_rlast : l1d_rlast), 64'(b == int'(exp_len)));
         check({tag, "_other_rvalid"}, 64'(is_i ? l1d_rvalid : l1i_rvalid), 64'd0);
         tick();
         check({tag, "_rready_pulse"}, 64'(l1i_rready | l1d_rready), 64'd0);
      end
      mem_rvalid = 1'b0;
      mem_rlast  = 1'b0;
      check({tag, "_rready_done"}, 64'(mem_rready), 64'd0);
   endtask

   initial begin
      reset       = 1'b1;
      l1i_arvalid = 1'b0;
      l1i_araddr  = '0;
      l1d_arvalid = 1'b0;
      l1d_araddr  = '0;
      l1d_rstrb   = '0;
      l1d_awvalid = 1'b0;
      l1d_awaddr  = '0;
      l1d_wvalid  = 1'b0;
      l1d_wdata   = '0;
      l1d_wstrb   = '0;
      mem_arready = 1'b0;
      mem_rvalid  = 1'b0;
      mem_rdata   = '0;
      mem_rlast   = 1'b0;
      mem_awready = 1'b0;
      mem_wready  = 1'b0;
      mem_bvalid  = 1'b0;
      tick();
      tick();

      // Reset state.
      check_quiet("rst");
      check("rst_araddr", mem_araddr, 64'd0);
      check("rst_awaddr", mem_awaddr, 64'd0);
      check("rst_wdata",  mem_wdata,  64'd0);

      // Ifetch burst: arready after 2 cycles, 4 beats.
      reset       = 1'b0;
      l1i_arvalid = 1'b1;
      l1i_araddr  = 64'h8000_0000;
      tick();
      l1i_araddr  = 64'h0bad_0bad;
      check("if_wait_arvalid", 64'(mem_arvalid), 64'd1);
      check("if_wait_araddr", mem_araddr, 64'h8000_0000);
      tick();
      do_read("ifetch", 64'h8000_0000, 8'd3, 8'hff, 1'b1, 1'b0);
      tick();
      check("if_idle_arvalid", 64'(mem_arvalid), 64'd0);

      // Contested reads held from reset.
      reset = 1'b1;
      tick();
      reset       = 1'b0;
      l1i_arvalid = 1'b1;
      l1i_araddr  = 64'h1000;
      l1d_arvalid = 1'b1;
      l1d_araddr  = 64'h2000;
      l1d_rstrb   = 8'hff;
      tick();
`ifdef YSYX_BUS_ARB_RR_EN
      do_read("rr1", 64'h1000, 8'd3, 8'hff, 1'b1, 1'b1);
      tick();
      do_read("rr2", 64'h2000, 8'd0, 8'hff, 1'b0, 1'b1);
      tick();
      do_read("rr3", 64'h1000, 8'd3, 8'hff, 1'b1, 1'b1);
`else
      do_read("fp1", 64'h2000, 8'd0, 8'hff, 1'b0, 1'b1);
      tick();
      do_read("fp2", 64'h2000, 8'd0, 8'hff, 1'b0, 1'b1);
      tick();
      do_read("fp3", 64'h2000, 8'd0, 8'hff, 1'b0, 1'b1);
`endif
      l1i_arvalid = 1'b0;
      l1d_arvalid = 1'b0;
      tick();
      check("ct_idle_arvalid", 64'(mem_arvalid), 64'd0);

      // Write beats a simultaneous ifetch.
      l1d_awvalid = 1'b1;
      l1d_wvalid  = 1'b1;
      l1d_awaddr  = 64'h8000_0100;
      l1d_wdata   = 64'hdead_beef;
      l1d_wstrb   = 8'h0f;
      l1i_arvalid = 1'b1;
      l1i_araddr  = 64'h3000;
      tick();
      l1d_wdata   = 64'h1234;
      check("wr_awvalid", 64'(mem_awvalid), 64'd1);
      check("wr_wvalid",  64'(mem_wvalid),  64'd1);
      check("wr_arvalid", 64'(mem_arvalid), 64'd0);
      check("wr_awaddr",  mem_awaddr, 64'h8000_0100);
      check("wr_wdata",   mem_wdata,  64'hdead_beef);
      check("wr_wstrb",   64'(mem_wstrb), 64'h0f);
      mem_awready = 1'b1;
      mem_wready  = 1'b1;
      tick();
      mem_awready = 1'b0;
      mem_wready  = 1'b0;
      check("wr_aw_off", 64'(mem_awvalid), 64'd0);
      check("wr_w_off",  64'(mem_wvalid),  64'd0);
      check("wr_bready", 64'(mem_bready),  64'd1);
      tick();
      check("wr_bwait_bready", 64'(mem_bready), 64'd1);
      check("wr_bwait_wready", 64'(l1d_wready), 64'd0);
      mem_bvalid = 1'b1;
      tick();
      mem_bvalid  = 1'b0;
      check("wr_wready_pulse", 64'(l1d_wready), 64'd1);
      check("wr_bready_off",   64'(mem_bready), 64'd0);
      l1d_awvalid = 1'b0;
      l1d_wvalid  = 1'b0;
      tick();
      check("wr_wready_end", 64'(l1d_wready), 64'd0);
      check("wr_no_reissue", 64'(mem_awvalid), 64'd0);
      do_read("wr_then_i", 64'h3000, 8'd3, 8'hff, 1'b1, 1'b0);
      tick();

      // W accepted 3 cycles before AW.
      l1d_awvalid = 1'b1;
      l1d_wvalid  = 1'b1;
      l1d_awaddr  = 64'h4000;
      l1d_wdata   = 64'h55;
      l1d_wstrb   = 8'hff;
      tick();
      mem_wready = 1'b1;
      tick();
      mem_wready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check("sk_w_off",     64'(mem_wvalid),  64'd0);
         check("sk_aw_hold",   64'(mem_awvalid), 64'd1);
         check("sk_no_bready", 64'(mem_bready),  64'd0);
         tick();
      end
      check("sk_aw_hold_last", 64'(mem_awvalid), 64'd1);
      mem_awready = 1'b1;
      tick();
      mem_awready = 1'b0;
      check("sk_aw_off", 64'(mem_awvalid), 64'd0);
      check("sk_bready", 64'(mem_bready),  64'd1);
      mem_bvalid = 1'b1;
      tick();
      mem_bvalid  = 1'b0;
      check("sk_wready", 64'(l1d_wready), 64'd1);
      l1d_awvalid = 1'b0;
      l1d_wvalid  = 1'b0;
      tick();
      check("sk_idle_awvalid", 64'(mem_awvalid), 64'd0);

      // Reset during beat 2 of an ifetch burst.
      l1i_arvalid = 1'b1;
      l1i_araddr  = 64'h5000;
      tick();
      mem_arready = 1'b1;
      tick();
      mem_arready = 1'b0;
      l1i_arvalid = 1'b0;
      mem_rvalid  = 1'b1;
      mem_rdata   = 64'h11;
      mem_rlast   = 1'b0;
      tick();
      mem_rdata = 64'h22;
      #1;
      check("mr_beat2_rvalid", 64'(l1i_rvalid), 64'd1);
      reset = 1'b1;
      tick();
      check_quiet("mr");
      reset       = 1'b0;
      mem_rvalid  = 1'b0;

      // Data read with a partial strobe, granted right after reset.
      l1d_arvalid = 1'b1;
      l1d_araddr  = 64'h6000;
      l1d_rstrb   = 8'h03;
      tick();
      do_read("strb", 64'h6000, 8'd0, 8'h03, 1'b0, 1'b0);
      tick();
      check_quiet("end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
